// File: rtl/alu_pkg.sv
// Package shared by the multicycle ALU slice.
// Holds the 4-bit ALU operation codes, the FSM state encodings and a small
// decode helper used by the top-level controller.
package alu_pkg;

    localparam int ALU_CODE_W = 4;

    localparam logic [ALU_CODE_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CODE_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CODE_W-1:0] ALU_MUL = 4'b0011;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_MUL  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // True for the codes that complete in a single cycle.
    function automatic logic is_simple_op(input logic [ALU_CODE_W-1:0] code);
        logic hit;
        hit = 1'b0;
        case (code)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: hit = 1'b1;
            default:                                   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Signed iterative shift-add multiplier.
// Operands are converted to magnitudes on go, multiplied unsigned over WIDTH
// steps, and the sign is re-applied to the final product.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   go           load operands and begin (ignored while running)
//   opa, opb     signed operands, sampled on go
//   fin          high during the cycle whose edge performs the last step
//   product      signed 2*WIDTH product, valid while fin is high
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    output logic               fin,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             active;
    logic             sign;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] mplr;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   hi_nxt;
    logic [WIDTH-1:0]   mplr_nxt;
    logic [2*WIDTH-1:0] raw;

    // Magnitudes are WIDTH-bit unsigned, so the most-negative value maps to 2^(WIDTH-1).
    assign abs_a = opa[WIDTH-1] ? -opa : opa;
    assign abs_b = opb[WIDTH-1] ? -opb : opb;

    // One step: conditionally add the multiplicand into the upper half, keeping
    // the carry, then shift the whole {carry, hi, mplr} right by one.
    assign sum      = {1'b0, hi} + {1'b0, (mplr[0] ? mcand : '0)};
    assign hi_nxt   = sum[WIDTH:1];
    assign mplr_nxt = {sum[0], mplr[WIDTH-1:1]};
    assign raw      = {hi_nxt, mplr_nxt};

    // Product reflects the step in flight, so the top can register it on the final edge.
    assign product = sign ? -raw : raw;
    assign fin     = active && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active <= 1'b0;
            sign   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            hi     <= '0;
            mplr   <= '0;
        end else if (!active) begin
            if (go) begin
                active <= 1'b1;
                sign   <= opa[WIDTH-1] ^ opb[WIDTH-1];
                cnt    <= CNT_W'(WIDTH - 1);
                mcand  <= abs_a;
                hi     <= '0;
                mplr   <= abs_b;
            end
        end else begin
            hi   <= hi_nxt;
            mplr <= mplr_nxt;
            cnt  <= cnt - CNT_W'(1);
            if (cnt == '0) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// EX-stage execution unit with a start/busy/done handshake.
// AND/OR/ADD/SUB/SLT finish in one cycle; MUL runs on seq_multiplier for
// WIDTH steps. Unknown codes complete immediately with illegal set.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for start, outputs hold last result
// MUL   | multiplier stepping, start ignored
// DONE  | done pulse, returns to IDLE unconditionally
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   start          op request, sampled only in IDLE
//   AluS           4-bit op code
//   OpA, OpB       operands, used only on the accepting edge
//   busy           high whenever not IDLE
//   done           one-cycle completion pulse
//   Result         result (low product half for MUL)
//   HiOut          high product half, updated by MUL only
//   Zero           Result == 0, registered with Result
//   illegal        last accepted code was not recognised
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ALU_CODE_W-1:0] AluS,
    input  logic [WIDTH-1:0]      OpA,
    input  logic [WIDTH-1:0]      OpB,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      Result,
    output logic [WIDTH-1:0]      HiOut,
    output logic                  Zero,
    output logic                  illegal
);

    logic [1:0]         state;
    logic [WIDTH-1:0]   simple_res;
    logic               slt_bit;
    logic               accept;
    logic               mul_go;
    logic               mul_fin;
    logic [2*WIDTH-1:0] mul_prod;

    assign accept = (state == ST_IDLE) && start;
    assign mul_go = accept && (AluS == ALU_MUL);
    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);

    assign slt_bit = ($signed(OpA) < $signed(OpB));

    always_comb begin
        simple_res = '0;
        case (AluS)
            ALU_AND: simple_res = OpA & OpB;
            ALU_OR:  simple_res = OpA | OpB;
            ALU_ADD: simple_res = OpA + OpB;
            ALU_SUB: simple_res = OpA - OpB;
            ALU_SLT: simple_res = {{(WIDTH-1){1'b0}}, slt_bit};
            default: simple_res = '0;
        endcase
    end

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (mul_go),
        .opa     (OpA),
        .opb     (OpB),
        .fin     (mul_fin),
        .product (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            Result  <= '0;
            HiOut   <= '0;
            Zero    <= 1'b1;
            illegal <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (AluS == ALU_MUL) begin
                            state   <= ST_MUL;
                            illegal <= 1'b0;
                        end else if (is_simple_op(AluS)) begin
                            state   <= ST_DONE;
                            Result  <= simple_res;
                            Zero    <= (simple_res == '0);
                            illegal <= 1'b0;
                        end else begin
                            state   <= ST_DONE;
                            Result  <= '0;
                            Zero    <= 1'b1;
                            illegal <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_fin) begin
                        state  <= ST_DONE;
                        HiOut  <= mul_prod[2*WIDTH-1:WIDTH];
                        Result <= mul_prod[WIDTH-1:0];
                        Zero   <= (mul_prod[WIDTH-1:0] == '0);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  AluS;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic        busy;
    logic        done;
    logic [31:0] Result;
    logic [31:0] HiOut;
    logic        Zero;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_hi = '0;

    multicycle_alu #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .AluS    (AluS),
        .OpA     (OpA),
        .OpB     (OpB),
        .busy    (busy),
        .done    (done),
        .Result  (Result),
        .HiOut   (HiOut),
        .Zero    (Zero),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the op definitions.
    task automatic model(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output bit ill);
        int    sa;
        int    sb;
        longint p;
        sa  = a;
        sb  = b;
        ill = 1'b0;
        r   = '0;
        case (code)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a + b;
            4'd6: r = a - b;
            4'd7: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd3: begin
                p      = longint'(sa) * longint'(sb);
                r      = p[31:0];
                exp_hi = p[63:32];
            end
            default: begin
                r   = '0;
                ill = 1'b1;
            end
        endcase
    endtask

    // Issue one op and follow it to completion. inject_at > 0 raises start
    // with an ADD code on that cycle of the wait, which must be ignored.
    task automatic do_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                         input logic [31:0] b, input int inject_at);
        logic [31:0] er;
        bit          ei;
        int          cyc;
        bit          got;
        bit          busy_bad;
        int          lat;
        model(code, a, b, er, ei);
        @(negedge clk);
        start = 1'b1;
        AluS  = code;
        OpA   = a;
        OpB   = b;
        cyc      = 0;
        got      = 1'b0;
        busy_bad = 1'b0;
        lat      = 0;
        while (!got && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = (cyc == inject_at);
            AluS  = (cyc == inject_at) ? 4'b0010 : 4'($urandom);
            OpA   = $urandom;
            OpB   = $urandom;
            if (!busy) busy_bad = 1'b1;
            if (done) begin
                got = 1'b1;
                lat = cyc;
                check({tag, "_result"}, Result, er);
                check({tag, "_hiout"}, HiOut, exp_hi);
                check({tag, "_zero"}, Zero, (er == 0));
                check({tag, "_illegal"}, illegal, ei);
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, got, 1);
        check({tag, "_busy_while_running"}, busy_bad, 0);
        if (got) check({tag, "_latency"}, lat, (code == 4'd3) ? 33 : 1);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_result"}, Result, 0);
        check({tag, "_hiout"}, HiOut, 0);
        check({tag, "_zero"}, Zero, 1);
        check({tag, "_illegal"}, illegal, 0);
    endtask

    logic [3:0]  legal_codes [6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd3};
    logic [3:0]  bad_codes   [4] = '{4'd4, 4'd5, 4'd8, 4'd15};
    logic [31:0] corners     [5] = '{32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1};

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int ndone;
        logic [3:0] c;
        rst_n = 1'b0;
        start = 1'b0;
        AluS  = '0;
        OpA   = '0;
        OpB   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_values("reset");
        rst_n = 1'b1;

        do_op("add_5_7", 4'b0010, 32'd5, 32'd7, 0);
        check("add_5_7_const", Result, 32'd12);
        do_op("sub_3_5", 4'b0110, 32'd3, 32'd5, 0);
        check("sub_3_5_const", Result, 32'hFFFF_FFFE);
        do_op("slt_neg1_1", 4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
        check("slt_const", Result, 32'd1);
        do_op("sub_9_9", 4'b0110, 32'd9, 32'd9, 0);
        check("sub_9_9_zero", Zero, 1);
        do_op("mul_m3_7", 4'b0011, 32'hFFFF_FFFD, 32'd7, 0);
        check("mul_m3_7_lo", Result, 32'hFFFF_FFEB);
        check("mul_m3_7_hi", HiOut, 32'hFFFF_FFFF);
        do_op("mul_min_2", 4'b0011, 32'h8000_0000, 32'd2, 0);
        check("mul_min_2_lo", Result, 32'h0);
        check("mul_min_2_hi", HiOut, 32'hFFFF_FFFF);
        do_op("mul_busy_reject", 4'b0011, 32'd1234, 32'hFFFF_FF00, 5);
        do_op("illegal_0101", 4'b0101, 32'd1, 32'd2, 0);
        do_op("add_after_illegal", 4'b0010, 32'd1, 32'd2, 0);
        check("illegal_cleared", illegal, 0);
        do_op("mul_min_min", 4'b0011, 32'h8000_0000, 32'h8000_0000, 0);

        // Reset in the middle of a multiply.
        @(negedge clk);
        start = 1'b1;
        AluS  = 4'b0011;
        OpA   = 32'd77;
        OpB   = 32'd99;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_values("mid_mul_reset");
        exp_hi = '0;
        rst_n  = 1'b1;
        ndone  = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) ndone++;
        end
        check("mid_mul_reset_no_done", ndone, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) c = bad_codes[$urandom_range(0, 3)];
            else c = legal_codes[$urandom_range(0, 5)];
            do_op($sformatf("rand%0d_op%0h", n, c), c, pick_operand(), pick_operand(),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
